rca_pipe_nb: RTL and testbench
==============================

# rca_pipe_nb

Parametrised, pipelined ripple-carry adder/subtractor with valid/ready handshakes on input and output. Operands are split into `STAGES` equal slices. Each pipeline stage ripples one slice and registers its carry into the next stage, so a `WIDTH`-bit add runs at slice-width clock rate with one result per cycle. It is the clocked successor of the 4-bit gate-level RCA and sits between operand producers and result consumers in datapath blocks.

## Interface
- `WIDTH`, 16: operand/result width in bits; must be a multiple of `STAGES`.
- `STAGES`, 4: pipeline depth; slice width is `WIDTH/STAGES`, and must be ≥1.
- `CLK` input 1: rising-edge clock.
- `RST_N` input 1: reset, asynchronous assert, active-low.
- `X` input WIDTH: operand A.
- `Y` input WIDTH: operand B.
- `C_IN` input 1: carry-in, used in add mode only.
- `SUB` input 1: 0 = `X+Y+C_IN`; 1 = `X-Y`, computed as `X+~Y+1` with `C_IN` ignored.
- `IN_VALID` input 1: operands valid.
- `IN_READY` output 1: block accepts operands this cycle.
- `SUM` output WIDTH: result.
- `C_OUT` output 1: carry-out of the MSB. In subtract mode, 1 means no borrow.
- `OVF` output 1: two's-complement signed overflow (see Configuration).
- `OUT_VALID` output 1: `SUM`/`C_OUT`/`OVF` valid.
- `OUT_READY` input 1: consumer accepts the result.

## Operation
- Stage k (0..STAGES-1) adds operand slice k using the carry registered by stage k-1. Stage 0 uses `C_IN`, or 1 when `SUB`=1.
- Operand slices not yet consumed are carried forward in delay registers, one register per stage, alongside the stage's valid bit.
- Result slices already produced are carried forward the same way, so `SUM` is fully aligned at the last stage.
- `Y` is inverted at the input when `SUB`=1. `SUB` is captured with the operands, so mixed add/sub streams are legal.
- Accept condition: `IN_VALID && IN_READY`.
- `IN_READY = RST_N && (!OUT_VALID || OUT_READY)`. This is a single global stall: every stage holds when `OUT_VALID && !OUT_READY`.
- When a stage advances without a valid input, its valid bit goes to 0 (a bubble). Bubbles are not compressed.
- Outputs are driven directly from last-stage registers. `SUM`, `C_OUT` and `OVF` hold stable while `OUT_VALID && !OUT_READY`.
- Arithmetic is modulo 2^WIDTH. `C_OUT` is bit WIDTH of the full sum.

## Timing
- Latency: an operand accepted at edge n produces `OUT_VALID`=1 after edge n+STAGES-1. The first result is visible STAGES cycles after acceptance with no stall.
- Throughput: 1 result per cycle when `OUT_READY` is held at 1.
- Stall adds exactly one cycle of latency per cycle of `OUT_READY`=0 while `OUT_VALID`=1. No data is lost or duplicated, and order is preserved.
- Simultaneous output pop and input push in the same cycle is legal and is required for full throughput.
- Reset (`RST_N`=0, asynchronous) forces immediately:
  - all valid bits, `OUT_VALID`, `SUM`, `C_OUT`, `OVF` to 0;
  - `IN_READY` to 0.
- Reset mid-operation discards all in-flight results. The first cycle after deassertion has `IN_READY`=1 and `OUT_VALID`=0.
- `STAGES`=1 degenerates to a registered full-width ripple adder with latency 1.

## Configuration
- `RCA_PIPE_OVF_EN` defined: `OVF` is computed as carry-into-MSB XOR carry-out-of-MSB and is pipelined with the result.
- `RCA_PIPE_OVF_EN` undefined: `OVF` is tied to 0, and no overflow logic or register is built. The port list is unchanged.

## Test plan
All scenarios use `WIDTH`=16, `STAGES`=4, `RCA_PIPE_OVF_EN` defined.

- **Single add:** `X`=0x0004, `Y`=0x0008, `C_IN`=0, `SUB`=0 → 4 cycles later `SUM`=0x000C, `C_OUT`=0, `OVF`=0.
- **Carry across slices / wrap:** back-to-back 0x00FF+0x0001 then 0xFFFF+0x0001 with `C_IN`=0 → 0x0100 (`C_OUT`=0), then 0x0000 (`C_OUT`=1), on consecutive cycles.
- **Subtract and signed overflow:** 0x0005−0x0007 → 0xFFFE, `C_OUT`=0, `OVF`=0. Then 0x7FFF+0x0001 → 0x8000, `OVF`=1. Then 0x8000−0x0001 → 0x7FFF, `OVF`=1.
- **Backpressure:** stream 8 operand pairs (i, 2i), i=0..7, with `IN_VALID`=1; hold `OUT_READY`=0 for 3 cycles mid-stream → `IN_READY` drops during the stall, all 8 results 3i arrive in order with no duplicates, and `SUM` is stable while stalled.
- **Reset mid-flight:** accept 3 operands, assert `RST_N`=0 for 1 cycle → `OUT_VALID`=0 and `IN_READY`=0 immediately, no stale results afterwards; a new 0x0003+0x0004 yields 0x0007 after 4 cycles.
- **Bubbles:** alternate `IN_VALID` 1/0 with `OUT_READY`=1 → `OUT_VALID` toggles 1/0 with matching results.

Source files
------------

// File: rtl/rca_pipe_nb_if.sv
// rtl/rca_pipe_nb_if.sv - operand/result handshake bundle for rca_pipe_nb
//
// Purpose: groups the operand input channel and the result output channel of
// the pipelined adder/subtractor.
// Ports (signals):
//   x, y       operands A and B (WIDTH bits)
//   c_in       carry-in, add mode only
//   sub        0 = x+y+c_in, 1 = x-y
//   in_valid   operands valid           in_ready   adder accepts operands
//   sum        result (WIDTH bits)      c_out      carry-out of MSB
//   ovf        signed overflow          out_valid  result valid
//   out_ready  consumer accepts result
// Modports: master = producer/consumer side, slave = adder side.
interface rca_pipe_nb_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c_in;
  logic             sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output x, y, c_in, sub, in_valid, out_ready,
    input  in_ready, sum, c_out, ovf, out_valid
  );

  modport slave (
    input  x, y, c_in, sub, in_valid, out_ready,
    output in_ready, sum, c_out, ovf, out_valid
  );
endinterface

// File: rtl/rca_pipe_nb.sv
// rtl/rca_pipe_nb.sv - pipelined ripple-carry adder/subtractor with valid/ready handshakes
//
// Purpose: splits WIDTH-bit operands into STAGES slices of WIDTH/STAGES bits.
// Stage k ripples slice k with the carry registered by stage k-1, so one
// result leaves per cycle with a latency of STAGES cycles.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rca_pipe_nb_if.slave (operands in, result out, valid/ready both ways)
// Configuration: define RCA_PIPE_OVF_EN to build the signed-overflow output;
// otherwise bus.ovf is tied to 0.
module rca_pipe_nb #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic          clk,
  input logic          rst_n,
  rca_pipe_nb_if.slave bus
);
  localparam int SW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // One global stall: the whole pipe freezes while a result waits for the consumer.
  logic adv;
  assign adv          = !(bus.out_valid && !bus.out_ready);
  assign bus.in_ready = rst_n && adv;

  for (genvar k = 0; k < STAGES; k++) begin : stg
    // Operand bits not yet consumed on entry to this stage; slice k sits at the bottom.
    localparam int AW = WIDTH - k * SW;

    logic [AW-1:0]         a_in;
    logic [AW-1:0]         b_in;
    logic                  ci;
    logic                  v_in;
    logic [SW:0]           res;
    logic [(k+1)*SW-1:0]   s_nxt;
    logic [(k+1)*SW-1:0]   s_q;
    logic                  c_q;
    logic                  v_q;

    if (k == 0) begin : src
      // Subtraction is x + ~y + 1; the +1 enters as the stage-0 carry.
      assign a_in  = bus.x;
      assign b_in  = bus.sub ? ~bus.y : bus.y;
      assign ci    = bus.sub | bus.c_in;
      assign v_in  = bus.in_valid;
      assign s_nxt = res[SW-1:0];
    end else begin : src
      assign a_in  = stg[k-1].fwd.a_q;
      assign b_in  = stg[k-1].fwd.b_q;
      assign ci    = stg[k-1].c_q;
      assign v_in  = stg[k-1].v_q;
      // Finished slices accumulate below the newest one, so the last stage holds the aligned sum.
      assign s_nxt = {res[SW-1:0], stg[k-1].s_q};
    end

    assign res = {1'b0, a_in[SW-1:0]} + {1'b0, b_in[SW-1:0]} + {{SW{1'b0}}, ci};

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_in;
        c_q <= res[SW];
        s_q <= s_nxt;
      end
    end

    // Only the slices later stages still need are carried forward.
    if (k < LAST) begin : fwd
      logic [AW-SW-1:0] a_q;
      logic [AW-SW-1:0] b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (adv) begin
          a_q <= a_in[AW-1:SW];
          b_q <= b_in[AW-1:SW];
        end
      end
    end
  end

  assign bus.sum       = stg[LAST].s_q;
  assign bus.c_out     = stg[LAST].c_q;
  assign bus.out_valid = stg[LAST].v_q;

`ifdef RCA_PIPE_OVF_EN
  // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
  logic ovf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (adv) begin
      ovf_q <= stg[LAST].a_in[SW-1] ^ stg[LAST].b_in[SW-1] ^
               stg[LAST].res[SW-1]  ^ stg[LAST].res[SW];
    end
  end

  assign bus.ovf = ovf_q;
`else
  assign bus.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_rca_pipe_nb.sv
// tb/tb_rca_pipe_nb.sv - self-checking bench for rca_pipe_nb
module tb_rca_pipe_nb;
  localparam int W = 16;
  localparam int S = 4;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         c_out;
    logic         ovf;
  } res_t;

`ifdef RCA_PIPE_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rca_pipe_nb_if #(.WIDTH(W)) bus ();

  rca_pipe_nb #(.WIDTH(W), .STAGES(S)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   vectors     = 0;
  int   miscompares = 0;
  res_t exp_q[$];

  // Reference: plain integer arithmetic on the whole operands.
  function automatic res_t ref_model(input logic [W-1:0] x, input logic [W-1:0] y,
                                     input logic cin, input logic sb);
    int   ux;
    int   uy;
    int   sx;
    int   sy;
    int   full;
    int   sres;
    res_t r;
    ux = int'(x);
    uy = int'(y);
    sx = int'($signed(x));
    sy = int'($signed(y));
    if (sb) begin
      full = ux + (65536 - uy);
      sres = sx - sy;
    end else begin
      full = ux + uy + int'(cin);
      sres = sx + sy + int'(cin);
    end
    r.sum   = full[W-1:0];
    r.c_out = full[W];
    r.ovf   = OVF_EN && (sres > 32767 || sres < -32768);
    return r;
  endfunction

  // One clock cycle: drive, sample just after, keep the scoreboard in step, advance.
  task automatic cyc(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                     input logic cin, input logic sb, input logic ordy,
                     output logic ov, output logic rdy, output res_t got,
                     output logic have, output res_t want);
    bus.in_valid  = v;
    bus.x         = x;
    bus.y         = y;
    bus.c_in      = cin;
    bus.sub       = sb;
    bus.out_ready = ordy;
    #1;
    ov   = bus.out_valid;
    rdy  = bus.in_ready;
    got  = {bus.sum, bus.c_out, bus.ovf};
    have = 1'b0;
    want = '0;
    if (ov && ordy) begin
      have = (exp_q.size() > 0);
      if (have) want = exp_q.pop_front();
    end
    if (v && rdy) exp_q.push_back(ref_model(x, y, cin, sb));
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    bus.in_valid  = 1'b0;
    bus.x         = '0;
    bus.y         = '0;
    bus.c_in      = 1'b0;
    bus.sub       = 1'b0;
    bus.out_ready = 1'b1;
    rst_n         = 1'b0;
    @(negedge clk);
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    vectors++;
    if (bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
    end
    vectors++;
    if ({bus.sum, bus.c_out, bus.ovf} !== {W+2{1'b0}}) begin
      miscompares++;
      $display("FAIL reset_outputs: got sum=%h c_out=%b ovf=%b want 0", bus.sum, bus.c_out, bus.ovf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    vectors++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
    end
    @(negedge clk);
  endtask

  task automatic test_single();
    logic ov, rdy, have;
    res_t got, want, hit;
    int   lat;
    cyc(1'b1, 16'h0004, 16'h0008, 1'b0, 1'b0, 1'b1, ov, rdy, got, have, want);
    vectors++;
    if (rdy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_accept: got in_ready=%b want 1", rdy);
    end
    lat = 0;
    hit = '0;
    for (int i = 1; i <= 10 && lat == 0; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ov, rdy, got, have, want);
      if (ov) begin
        lat = i;
        hit = got;
      end
    end
    vectors++;
    if (lat != S) begin
      miscompares++;
      $display("FAIL single_latency: got %0d cycles want %0d (0 = timeout)", lat, S);
    end
    vectors++;
    if (hit !== {16'h000C, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL single_result: got sum=%h c_out=%b ovf=%b want 000c 0 0", hit.sum, hit.c_out, hit.ovf);
    end
  endtask

  task automatic test_carry();
    logic [W-1:0] xs[2];
    logic [W-1:0] es[2];
    logic         ec[2];
    res_t         seen[$];
    int           when[$];
    logic         ov, rdy, have;
    res_t         got, want;
    xs = '{16'h00FF, 16'hFFFF};
    es = '{16'h0100, 16'h0000};
    ec = '{1'b0, 1'b1};
    for (int c = 0; c < 12; c++) begin
      cyc(c < 2, (c < 2) ? xs[c % 2] : 16'h0, (c < 2) ? 16'h0001 : 16'h0, 1'b0, 1'b0, 1'b1,
          ov, rdy, got, have, want);
      if (ov) begin
        seen.push_back(got);
        when.push_back(c);
      end
    end
    vectors++;
    if (seen.size() != 2) begin
      miscompares++;
      $display("FAIL carry_count: got %0d results want 2", seen.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (seen[i] !== {es[i], ec[i], 1'b0}) begin
          miscompares++;
          $display("FAIL carry_result[%0d]: got sum=%h c_out=%b ovf=%b want %h %b 0",
                   i, seen[i].sum, seen[i].c_out, seen[i].ovf, es[i], ec[i]);
        end
      end
      vectors++;
      if (when[1] != when[0] + 1) begin
        miscompares++;
        $display("FAIL carry_consecutive: got gap %0d want 1", when[1] - when[0]);
      end
    end
  endtask

  task automatic test_sub_ovf();
    logic [W-1:0] xs[3];
    logic [W-1:0] ys[3];
    logic         sbs[3];
    logic [W-1:0] es[3];
    logic         ec[3];
    logic         eo[3];
    int           n;
    logic         ov, rdy, have;
    res_t         got, want;
    xs  = '{16'h0005, 16'h7FFF, 16'h8000};
    ys  = '{16'h0007, 16'h0001, 16'h0001};
    sbs = '{1'b1, 1'b0, 1'b1};
    es  = '{16'hFFFE, 16'h8000, 16'h7FFF};
    ec  = '{1'b0, 1'b0, 1'b1};
    eo  = '{1'b0, OVF_EN, OVF_EN};
    n = 0;
    for (int c = 0; c < 12; c++) begin
      cyc(c < 3, xs[c % 3], ys[c % 3], 1'b0, sbs[c % 3], 1'b1, ov, rdy, got, have, want);
      if (ov) begin
        vectors++;
        if (n > 2) begin
          miscompares++;
          $display("FAIL subovf_extra: got unexpected sum=%h", got.sum);
        end else if (got !== {es[n], ec[n], eo[n]}) begin
          miscompares++;
          $display("FAIL subovf_result[%0d]: got sum=%h c_out=%b ovf=%b want %h %b %b",
                   n, got.sum, got.c_out, got.ovf, es[n], ec[n], eo[n]);
        end
        n++;
      end
    end
    vectors++;
    if (n != 3) begin
      miscompares++;
      $display("FAIL subovf_count: got %0d results want 3", n);
    end
  endtask

  task automatic test_backpressure();
    int       i, n;
    logic     ordy, prev_stall;
    logic [W-1:0] prev;
    logic     ov, rdy, have;
    res_t     got, want;
    i = 0;
    n = 0;
    prev_stall = 1'b0;
    prev = '0;
    for (int c = 0; c < 40 && n < 8; c++) begin
      ordy = !(c >= 5 && c <= 7);
      cyc(i < 8, 16'(i), 16'(2 * i), 1'b0, 1'b0, ordy, ov, rdy, got, have, want);
      if (i < 8 && rdy) i++;
      if (!ordy && ov) begin
        vectors++;
        if (rdy !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_in_ready: got %b want 0 at cycle %0d", rdy, c);
        end
      end
      if (prev_stall) begin
        vectors++;
        if (got.sum !== prev) begin
          miscompares++;
          $display("FAIL bp_hold: got sum=%h want %h at cycle %0d", got.sum, prev, c);
        end
      end
      prev_stall = ov && !ordy;
      prev       = got.sum;
      if (ov && ordy) begin
        vectors++;
        if (got !== {16'(3 * n), 1'b0, 1'b0}) begin
          miscompares++;
          $display("FAIL bp_result[%0d]: got sum=%h c_out=%b ovf=%b want %h 0 0",
                   n, got.sum, got.c_out, got.ovf, 16'(3 * n));
        end
        n++;
      end
    end
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL bp_count: got %0d results want 8", n);
    end
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ov, rdy, got, have, want);
      vectors++;
      if (ov !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_extra: got out_valid=%b sum=%h want no result", ov, got.sum);
      end
    end
  endtask

  task automatic test_bubbles();
    logic vh[20];
    logic v, ov, rdy, have;
    res_t got, want;
    for (int c = 0; c < 20; c++) begin
      v = (c % 2 == 0);
      cyc(v, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b1,
          ov, rdy, got, have, want);
      vh[c] = v && rdy;
      if (c >= S) begin
        vectors++;
        if (ov !== vh[c-S]) begin
          miscompares++;
          $display("FAIL bubble_valid: got %b want %b at cycle %0d", ov, vh[c-S], c);
        end
      end
      if (ov) begin
        vectors++;
        if (!have || got !== want) begin
          miscompares++;
          $display("FAIL bubble_result: got sum=%h c_out=%b ovf=%b want %h %b %b (expected=%b)",
                   got.sum, got.c_out, got.ovf, want.sum, want.c_out, want.ovf, have);
        end
      end
    end
    for (int c = 0; c < 6; c++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ov, rdy, got, have, want);
    end
  endtask

  task automatic test_reset_mid();
    int   pops;
    logic ov, rdy, have;
    res_t got, want;
    for (int c = 0; c < 3; c++) begin
      cyc(1'b1, 16'($urandom), 16'($urandom), 1'b0, 1'b0, 1'b1, ov, rdy, got, have, want);
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_immediate: got out_valid=%b in_ready=%b want 0 0", bus.out_valid, bus.in_ready);
    end
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, 16'h0003, 16'h0004, 1'b0, 1'b0, 1'b1, ov, rdy, got, have, want);
    vectors++;
    if (rdy !== 1'b1 || ov !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_release: got in_ready=%b out_valid=%b want 1 0", rdy, ov);
    end
    pops = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ov, rdy, got, have, want);
      if (ov) begin
        vectors++;
        if (pops != 0 || i != S || got.sum !== 16'h0007 || got.c_out !== 1'b0) begin
          miscompares++;
          $display("FAIL rstmid_result: got sum=%h c_out=%b at cycle %0d (result %0d) want 0007 0 at cycle %0d",
                   got.sum, got.c_out, i, pops, S);
        end
        pops++;
      end
    end
    vectors++;
    if (pops != 1) begin
      miscompares++;
      $display("FAIL rstmid_count: got %0d results want 1", pops);
    end
  endtask

  task automatic test_random();
    logic v, ordy, ov, rdy, have;
    res_t got, want;
    for (int c = 0; c < 300; c++) begin
      v    = 1'($urandom);
      ordy = ($urandom_range(0, 3) != 0);
      cyc(v, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), ordy,
          ov, rdy, got, have, want);
      vectors++;
      if (rdy !== (!ov || ordy)) begin
        miscompares++;
        $display("FAIL rand_in_ready: got %b want %b at cycle %0d", rdy, (!ov || ordy), c);
      end
      if (ov && ordy) begin
        vectors++;
        if (!have || got !== want) begin
          miscompares++;
          $display("FAIL rand_result: got sum=%h c_out=%b ovf=%b want %h %b %b (expected=%b) at cycle %0d",
                   got.sum, got.c_out, got.ovf, want.sum, want.c_out, want.ovf, have, c);
        end
      end
    end
    for (int c = 0; c < 20; c++) begin
      cyc(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, ov, rdy, got, have, want);
      if (ov) begin
        vectors++;
        if (!have || got !== want) begin
          miscompares++;
          $display("FAIL rand_drain: got sum=%h c_out=%b ovf=%b want %h %b %b (expected=%b)",
                   got.sum, got.c_out, got.ovf, want.sum, want.c_out, want.ovf, have);
        end
      end
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL rand_lost: got %0d results never delivered want 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_carry();
    test_sub_ovf();
    test_backpressure();
    test_bubbles();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
